// File: rtl/alu_seq_ctrl.sv
// Sequencer for an external combinational ALU: request/response handshake, op counter.
// Define ALU_SEQ_SELFTEST_EN to build in the exhaustive ALU self-test sweep.
module alu_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic         req_cin,
  input  logic [2:0]   req_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_c_in,
  output logic [2:0]   alu_c,
  input  logic [N-1:0] alu_f,
  input  logic         alu_c_out,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_f,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_z,
  output logic [15:0]  op_count,
  input  logic         st_start,
  output logic         st_busy,
  output logic         st_done,
  output logic         st_fail,
  output logic [15:0]  st_err_count
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    RESP
`ifdef ALU_SEQ_SELFTEST_EN
    , ST_DRIVE,
    ST_CHECK
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic         alu_c_in_q, alu_c_in_d;
  logic [2:0]   alu_c_q, alu_c_d;
  logic [N-1:0] rsp_f_q, rsp_f_d;
  logic         rsp_c_q, rsp_c_d, rsp_v_q, rsp_v_d, rsp_z_q, rsp_z_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [15:0]  op_count_q, op_count_d;
  logic         accept;

`ifdef ALU_SEQ_SELFTEST_EN
  localparam int VW = 2 * N + 4;

  logic [VW-1:0] vec_q, vec_d;
  logic          st_busy_q, st_busy_d, st_done_q, st_done_d, st_fail_q, st_fail_d;
  logic [15:0]   st_err_q, st_err_d;
  logic [N-1:0]  m_bb, m_f, m_low;
  logic [N:0]    m_sum;
  logic          m_v, mismatch;

  // Reference ALU evaluated on the vector currently driven on alu_*.
  always_comb begin
    m_bb  = alu_c_q[0] ? ~alu_b_q : alu_b_q;
    m_sum = {1'b0, alu_a_q} + {1'b0, m_bb} + (N+1)'(alu_c_in_q);
    m_low = {1'b0, alu_a_q[N-2:0]} + {1'b0, m_bb[N-2:0]} + N'(alu_c_in_q);
    m_v   = m_low[N-1] ^ m_sum[N];
    case (alu_c_q)
      3'b000, 3'b001: m_f = m_sum[N-1:0];
      3'b010:         m_f = alu_a_q | alu_b_q;
      3'b011:         m_f = alu_a_q | ~alu_b_q;
      3'b100:         m_f = alu_a_q & alu_b_q;
      3'b101:         m_f = alu_a_q & ~alu_b_q;
      3'b110:         m_f = ~alu_a_q;
      default:        m_f = ~alu_b_q;
    endcase
    mismatch = (alu_f != m_f) || (alu_c_out != m_sum[N]) || (alu_v != m_v);
  end
`else
  logic unused_st_start;
  assign unused_st_start = st_start;
`endif

  always_comb begin
    req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_in_d  = alu_c_in_q;
    alu_c_d     = alu_c_q;
    rsp_f_d     = rsp_f_q;
    rsp_c_d     = rsp_c_q;
    rsp_v_d     = rsp_v_q;
    rsp_z_d     = rsp_z_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
`ifdef ALU_SEQ_SELFTEST_EN
    vec_d       = vec_q;
    st_busy_d   = st_busy_q;
    st_done_d   = st_done_q;
    st_fail_d   = st_fail_q;
    st_err_d    = st_err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ALU_SEQ_SELFTEST_EN
        if (!req_valid && st_start) begin
          st_busy_d = 1'b1;
          st_done_d = 1'b0;
          st_fail_d = 1'b0;
          st_err_d  = '0;
          vec_d     = '0;
          state_d   = ST_DRIVE;
        end
`endif
      end
      EXEC: begin
        rsp_f_d     = alu_f;
        rsp_c_d     = alu_c_out;
        rsp_v_d     = alu_v;
        rsp_z_d     = (alu_f == '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
`ifdef ALU_SEQ_SELFTEST_EN
      ST_DRIVE: begin
        alu_a_d    = vec_q[N-1:0];
        alu_b_d    = vec_q[2*N-1:N];
        alu_c_in_d = vec_q[2*N];
        alu_c_d    = vec_q[2*N+3:2*N+1];
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          st_fail_d = 1'b1;
          if (st_err_q != '1) st_err_d = st_err_q + 16'd1;
        end
        if (vec_q == '1) begin
          st_busy_d = 1'b0;
          st_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = ST_DRIVE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // An accept in RESP overrides the return to IDLE, giving back-to-back issue.
    if (accept) begin
      alu_a_d    = req_a;
      alu_b_d    = req_b;
      alu_c_in_d = req_cin;
      alu_c_d    = req_op;
      state_d    = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_in_q  <= 1'b0;
      alu_c_q     <= '0;
      rsp_f_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
`ifdef ALU_SEQ_SELFTEST_EN
      vec_q       <= '0;
      st_busy_q   <= 1'b0;
      st_done_q   <= 1'b0;
      st_fail_q   <= 1'b0;
      st_err_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_in_q  <= alu_c_in_d;
      alu_c_q     <= alu_c_d;
      rsp_f_q     <= rsp_f_d;
      rsp_c_q     <= rsp_c_d;
      rsp_v_q     <= rsp_v_d;
      rsp_z_q     <= rsp_z_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
`ifdef ALU_SEQ_SELFTEST_EN
      vec_q       <= vec_d;
      st_busy_q   <= st_busy_d;
      st_done_q   <= st_done_d;
      st_fail_q   <= st_fail_d;
      st_err_q    <= st_err_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c_in  = alu_c_in_q;
  assign alu_c     = alu_c_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_valid = rsp_valid_q;
  assign op_count  = op_count_q;
`ifdef ALU_SEQ_SELFTEST_EN
  assign st_busy      = st_busy_q;
  assign st_done      = st_done_q;
  assign st_fail      = st_fail_q;
  assign st_err_count = st_err_q;
`else
  assign st_busy      = 1'b0;
  assign st_done      = 1'b0;
  assign st_fail      = 1'b0;
  assign st_err_count = '0;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: N, 4, ALU operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present; req_ready  output  1  request accepted when both high at an edge.
REQ-005 req_a, req_b  input  N each  operands; req_cin  input  1  carry in; req_op  input  3  operation select.
REQ-006 alu_a, alu_b  output  N each; alu_c_in  output  1; alu_c  output  3; these drive the external combinational ALU.
REQ-007 alu_f  input  N; alu_c_out  input  1; alu_v  input  1; these are the external ALU results.
REQ-008 rsp_valid  output  1; rsp_ready  input  1; a response transfers when both are high at an edge.
REQ-009 rsp_f  output  N; rsp_c  output  1; rsp_v  output  1; rsp_z  output  1 (rsp_f==0); op_count  output  16.
REQ-010 st_start  input  1; st_busy, st_done, st_fail  output  1 each; st_err_count  output  16.

Function
REQ-011 The FSM SHALL have states IDLE, EXEC, RESP, and ST_DRIVE, ST_CHECK when self-test is compiled in.
REQ-012 req_ready SHALL be high in IDLE, and in RESP while rsp_ready=1; it SHALL be low otherwise.
REQ-013 On accept, the block SHALL register req_a/req_b/req_cin/req_op onto alu_a/alu_b/alu_c_in/alu_c and go to EXEC.
REQ-014 alu_* outputs SHALL hold stable from accept until the next accept or reset.
REQ-015 The EXEC edge SHALL sample alu_f/alu_c_out/alu_v into rsp_f/rsp_c/rsp_v, set rsp_z, set rsp_valid=1, and go to RESP.
REQ-016 Latency: rsp_valid SHALL rise exactly 2 edges after the accept edge.
REQ-017 In RESP with rsp_ready=0, all rsp_* SHALL hold unchanged.
REQ-018 On a response transfer, op_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-019 On a response transfer with no simultaneous accept, rsp_valid SHALL go low and the FSM SHALL go to IDLE.
REQ-020 On a response transfer with a simultaneous accept, rsp_valid SHALL go low and the FSM SHALL go to EXEC with the new operands (back-to-back throughput: 1 op per 2 cycles).
REQ-021 rsp_* SHALL change only at the EXEC capture edge or at reset.
REQ-022 ALU model (defined for self-test): add operand bb = c[0] ? ~b : b; sum = a + bb + cin.
REQ-023 ALU model c_out: carry out of sum for all ops; V: carry into bit N-1 XOR c_out, for all ops.
REQ-024 ALU model f, by op: 000 sum; 001 sum; 010 a|b; 011 a|~b; 100 a&b; 101 a&~b; 110 ~a; 111 ~b.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear to zero: alu_*, rsp_*, rsp_valid, op_count, st_busy, st_done, st_fail, st_err_count.
REQ-026 Reset SHALL take priority over any handshake and abort any in-flight operation or self-test; no response is produced for an aborted operation.

Configuration
REQ-027 Macro ALU_SEQ_SELFTEST_EN SHALL control the built-in exhaustive self-test.
REQ-028 With ALU_SEQ_SELFTEST_EN: st_start=1 in IDLE with req_valid=0 SHALL clear st_done/st_fail/st_err_count, set st_busy, and go to ST_DRIVE; req_valid=1 in the same cycle wins and st_start is ignored.
REQ-029 Self-test sweep: vector v SHALL run 0..2^(2N+4)-1, driving a=v[N-1:0], b=v[2N-1:N], cin=v[2N], op=v[2N+3:2N+1].
REQ-030 Each vector SHALL take 2 cycles: ST_DRIVE drives the ALU; ST_CHECK compares alu_f/alu_c_out/alu_v against the REQ-022..024 model.
REQ-031 On a self-test mismatch, st_fail SHALL set (sticky) and st_err_count SHALL increment, saturating at 0xFFFF.
REQ-032 After the last vector: st_busy=0, st_done=1 (held until the next st_start or reset), FSM to IDLE.
REQ-033 During self-test: req_ready=0, rsp_valid=0, and op_count unchanged.
REQ-034 Without ALU_SEQ_SELFTEST_EN: all ports SHALL remain present, st_start SHALL be ignored, and st_* outputs SHALL be constant 0.

Verification
REQ-035 a=0x7,b=0x1,cin=0,op=000 -> rsp_valid 2 edges after accept; rsp_f=0x8,c=0,v=1,z=0; op_count=1 after transfer.
REQ-036 a=0x5,b=0x5,cin=1,op=001 -> rsp_f=0x0,c=1,v=0,z=1.
REQ-037 a=0xA,b=0x5,cin=0,op=010 -> rsp_f=0xF,c=0,v=0,z=0.
REQ-038 rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, op_count unchanged.
REQ-039 (REQ-038 continued) then rsp_ready=1 with req_valid=1 -> new request accepted that edge, op_count+1, next rsp_valid 2 edges later.
REQ-040 rst pulsed while in EXEC -> next cycle all outputs 0, IDLE, req_ready=1, no response emitted.
REQ-041 ALU_SEQ_SELFTEST_EN, correct ALU, st_start pulse -> st_busy high 8192 cycles, then st_done=1, st_fail=0, st_err_count=0.
REQ-042 ALU_SEQ_SELFTEST_EN, alu_v stuck at 0, st_start pulse -> st_fail=1, st_err_count>0.
